// File: rtl/inv_mix_column_if.sv
// Handshake bundle for the InvMixColumns stage: input state, output state and busy flag.
// The design attaches to the slave modport and the producer/consumer to the master modport.
interface inv_mix_column_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] state_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] state_o;
  logic         busy_o;

  modport slave (
    input  in_valid_i, state_i, out_ready_i,
    output in_ready_o, out_valid_o, state_o, busy_o
  );

  modport master (
    output in_valid_i, state_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_o, busy_o
  );
endinterface

// File: rtl/inv_mix_column.sv
// AES InvMixColumns, column-serial: a captured state is transformed COLS_PER_CYCLE columns
// per clock in a work register, then held in state_o until the consumer accepts it.
module inv_mix_column #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  inv_mix_column_if.slave  bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_column: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Column counter only ever holds multiples of COLS_PER_CYCLE, so a window never wraps.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [2:0] WIN      = 3'(COLS_PER_CYCLE);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int r = 0; r < 4; r++) begin
      s[r]  = c[31-8*r -: 8];
      x2[r] = xtime(s[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ s[r];
      mb[r] = x8[r] ^ x2[r] ^ s[r];
      md[r] = x8[r] ^ x4[r] ^ s[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    inv_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
               m9[0] ^ me[1] ^ mb[2] ^ md[3],
               md[0] ^ m9[1] ^ me[2] ^ mb[3],
               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_e         state_r, state_nx;
  logic [1:0]     col_r, col_nx;
  logic [127:0]   work_r, work_nx;
  logic [127:0]   result_r, result_nx;
  logic           out_valid_r, out_valid_nx;
  logic           in_ready_r, in_ready_nx;
  logic           busy_r, busy_nx;
  logic [127:0]   cols_s;

  // Work register with the current column window replaced by its transform.
  always_comb begin
    cols_s = work_r;
    for (int j = 0; j < 4; j++) begin
      if (2'(j) >= col_r && {1'b0, 2'(j)} < ({1'b0, col_r} + WIN)) begin
        cols_s[127-32*j -: 32] = inv_col(work_r[127-32*j -: 32]);
      end else begin
        cols_s[127-32*j -: 32] = work_r[127-32*j -: 32];
      end
    end
  end

  // Next-state, datapath and output decode for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_nx     = state_r;
    col_nx       = col_r;
    work_nx      = work_r;
    result_nx    = result_r;
    out_valid_nx = out_valid_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid_i && in_ready_r) begin
          work_nx  = bus.state_i;
          col_nx   = 2'd0;
          state_nx = BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        work_nx = cols_s;
        if (col_r == LAST_COL) begin
          result_nx    = cols_s;
          out_valid_nx = 1'b1;
          col_nx       = 2'd0;
          state_nx     = DONE;
        end else begin
          col_nx   = col_r + COL_STEP;
          state_nx = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        out_valid_nx = 1'b0;
        col_nx       = 2'd0;
        state_nx     = IDLE;
      end
    endcase
    in_ready_nx = (state_nx == IDLE);
    busy_nx     = (state_nx == BUSY);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      col_r       <= 2'd0;
      work_r      <= 128'd0;
      result_r    <= 128'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      col_r       <= col_nx;
      work_r      <= work_nx;
      result_r    <= result_nx;
      out_valid_r <= out_valid_nx;
      in_ready_r  <= in_ready_nx;
      busy_r      <= busy_nx;
    end
  end

  assign bus.in_ready_o  = in_ready_r;
  assign bus.out_valid_o = out_valid_r;
  assign bus.state_o     = result_r;
  assign bus.busy_o      = busy_r;

endmodule

// File: tb/tb_inv_mix_column.sv
// Drives three inv_mix_column instances (1, 2 and 4 columns per clock) with the same stimulus
// and compares each against scoreboard queues filled with independently derived expectations.
module tb_inv_mix_column;

  localparam logic [127:0] T1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] T1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] state_in;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  logic [127:0] q1 [$];
  logic [127:0] q2 [$];
  logic [127:0] q4 [$];

  always #5 clk_i = ~clk_i;

  inv_mix_column_if if1 ();
  inv_mix_column_if if2 ();
  inv_mix_column_if if4 ();

  assign if1.in_valid_i  = in_valid;
  assign if1.state_i     = state_in;
  assign if1.out_ready_i = out_ready;
  assign if2.in_valid_i  = in_valid;
  assign if2.state_i     = state_in;
  assign if2.out_ready_i = out_ready;
  assign if4.in_valid_i  = in_valid;
  assign if4.state_i     = state_in;
  assign if4.out_ready_i = out_ready;

  inv_mix_column #(.COLS_PER_CYCLE(1)) u_c1 (.clk_i(clk_i), .rst_n(rst_n), .bus(if1.slave));
  inv_mix_column #(.COLS_PER_CYCLE(2)) u_c2 (.clk_i(clk_i), .rst_n(rst_n), .bus(if2.slave));
  inv_mix_column #(.COLS_PER_CYCLE(4)) u_c4 (.clk_i(clk_i), .rst_n(rst_n), .bus(if4.slave));

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward (encrypt) MixColumns, used to build round-trip stimulus.
  function automatic logic [127:0] mix_state(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] din, input logic [127:0] exp, input bit hold);
    int n = 0;
    int lat1 = 0;
    int lat2 = 0;
    int lat4 = 0;
    logic [127:0] snap1, snap2, snap4;
    while (!(if1.in_ready_o && if2.in_ready_o && if4.in_ready_o) && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("ready_wait", 128'(n < 20), 128'd1);
    @(negedge clk_i);
    in_valid = 1'b1;
    state_in = din;
    q1.push_back(exp);
    q2.push_back(exp);
    q4.push_back(exp);
    @(posedge clk_i); #1;
    in_valid = 1'b0;
    state_in = '1;
    chk("busy_after_accept",
        {if1.busy_o, if2.busy_o, if4.busy_o, if1.in_ready_o, if2.in_ready_o, if4.in_ready_o},
        6'b111_000);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk_i); #1;
      if (lat1 == 0 && if1.out_valid_o) lat1 = e;
      if (lat2 == 0 && if2.out_valid_o) lat2 = e;
      if (lat4 == 0 && if4.out_valid_o) lat4 = e;
    end
    chk("latency_c1_c2_c4", {lat1[3:0], lat2[3:0], lat4[3:0]}, 12'h421);
    chk("result_c1", if1.state_o, q1.pop_front());
    chk("result_c2", if2.state_o, q2.pop_front());
    chk("result_c4", if4.state_o, q4.pop_front());
    chk("done_flags",
        {if1.in_ready_o, if2.in_ready_o, if4.in_ready_o, if1.out_valid_o, if2.out_valid_o,
         if4.out_valid_o, if1.busy_o, if2.busy_o, if4.busy_o},
        9'b000_111_000);
    if (hold) begin
      snap1 = if1.state_o;
      snap2 = if2.state_o;
      snap4 = if4.state_o;
      in_valid = 1'b1;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 10; k++) begin
        @(posedge clk_i); #1;
        chk("hold_c1", if1.state_o, snap1);
        chk("hold_c2", if2.state_o, snap2);
        chk("hold_c4", if4.state_o, snap4);
        chk("hold_flags",
            {if1.in_ready_o, if2.in_ready_o, if4.in_ready_o, if1.out_valid_o, if2.out_valid_o,
             if4.out_valid_o}, 6'b000_111);
      end
      in_valid = 1'b0;
    end
    @(negedge clk_i);
    out_ready = 1'b1;
    @(posedge clk_i); #1;
    out_ready = 1'b0;
    chk("release_idle",
        {if1.in_ready_o, if2.in_ready_o, if4.in_ready_o, if1.out_valid_o, if2.out_valid_o,
         if4.out_valid_o}, 6'b111_000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = 128'd0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_state_o", if1.state_o | if2.state_o | if4.state_o, 128'd0);
    chk("reset_flags",
        {if1.in_ready_o, if2.in_ready_o, if4.in_ready_o, if1.out_valid_o, if2.out_valid_o,
         if4.out_valid_o, if1.busy_o, if2.busy_o, if4.busy_o}, 9'b111_000_000);
    @(negedge clk_i);
    rst_n = 1'b1;

    // FIPS vector; state_i is forced to all-ones right after accept
    send(T1_IN, T1_OUT, 1'b0);
    // backpressure with ignored in_valid
    send(T1_IN, T1_OUT, 1'b1);

    // asynchronous reset while the 1-column instance is on column 2
    @(negedge clk_i);
    in_valid = 1'b1;
    state_in = T1_IN;
    @(posedge clk_i); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_state_o", if1.state_o | if2.state_o | if4.state_o, 128'd0);
    chk("midreset_flags",
        {if1.in_ready_o, if2.in_ready_o, if4.in_ready_o, if1.out_valid_o, if2.out_valid_o,
         if4.out_valid_o, if1.busy_o, if2.busy_o, if4.busy_o}, 9'b111_000_000);
    @(negedge clk_i);
    rst_n = 1'b1;
    send(T1_IN, T1_OUT, 1'b0);

    // round trip, including the all-zero and all-ones fixed points
    send(mix_state(128'd0), 128'd0, 1'b0);
    send(mix_state('1), '1, 1'b0);
    chk("all_ff_fixed_point", mix_state('1), '1);
    for (int i = 0; i < 198; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      send(mix_state(r), r, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
